// File: rtl/jtag_bank_pkg.sv
// rtl/jtag_bank_pkg.sv - shared opcode/state enums and ID constant for the JTAG register bank
package jtag_bank_pkg;

  typedef enum logic [1:0] {
    OP_READ        = 2'b00,
    OP_WRITE       = 2'b01,
    OP_READ_WRITE  = 2'b10,
    OP_BURST_WRITE = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE
  } state_e;

  localparam logic [31:0] JTAG_BANK_ID = 32'h4A544147;

endpackage

// File: rtl/jtag_edge_detect.sv
// rtl/jtag_edge_detect.sv - registered rising-edge pulse for one already-synchronised JTAG level
module jtag_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;
  logic rise_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/jtag_register_bank.sv
// rtl/jtag_register_bank.sv - virtual-JTAG register bank with read/write/burst access
// Defining JTAG_BANK_PARITY_EN adds an even-parity bit per word and the oPARITY_ERRORS counter.
module jtag_register_bank
  import jtag_bank_pkg::*;
#(
  parameter  int REGISTER_SIZE       = 8,
  parameter  int NUMBER_OF_REGISTERS = 4,
  localparam int ADDRESS_WIDTH       = $clog2(NUMBER_OF_REGISTERS + 1),
  localparam int IR_WIDTH            = ADDRESS_WIDTH + 2
) (
  input  logic                                               iMAIN_CLK,
  input  logic                                               iRESET,
  input  logic [IR_WIDTH-1:0]                                iADDRESS,
  input  logic                                               iTCK,
  input  logic                                               iTDI,
  input  logic                                               iSTATE_CDR,
  input  logic                                               iSTATE_SDR,
  input  logic                                               iSTATE_UDR,
  output logic                                               oTDO,
  input  logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0]  iDATA,
  output logic [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0]  oDATA,
  output logic [NUMBER_OF_REGISTERS-1:0]                     oWRITE_STROBE
`ifdef JTAG_BANK_PARITY_EN
  ,
  output logic [7:0]                                         oPARITY_ERRORS
`endif
);

`ifdef JTAG_BANK_PARITY_EN
  localparam int W = REGISTER_SIZE + 1;
`else
  localparam int W = REGISTER_SIZE;
`endif
  localparam int CW = $clog2(W + 1);
  localparam int N  = NUMBER_OF_REGISTERS;
  localparam int AW = ADDRESS_WIDTH;

  logic tck_rise, cdr_rise, sdr_rise, udr_rise;

  jtag_edge_detect u_tck (.clk_i(iMAIN_CLK), .rst_i(iRESET), .sig_i(iTCK),       .rise_o(tck_rise));
  jtag_edge_detect u_cdr (.clk_i(iMAIN_CLK), .rst_i(iRESET), .sig_i(iSTATE_CDR), .rise_o(cdr_rise));
  jtag_edge_detect u_sdr (.clk_i(iMAIN_CLK), .rst_i(iRESET), .sig_i(iSTATE_SDR), .rise_o(sdr_rise));
  jtag_edge_detect u_udr (.clk_i(iMAIN_CLK), .rst_i(iRESET), .sig_i(iSTATE_UDR), .rise_o(udr_rise));

  state_e                  state_q, state_d;
  opcode_e                 op_q;
  logic [AW-1:0]           addr_q, ptr_q;
  logic [CW-1:0]           count_q;
  logic [W-1:0]            shift_q, shifted, cap_word;
  logic [REGISTER_SIZE-1:0] cap_data;
  logic [N-1:0][REGISTER_SIZE-1:0] data_q;
  logic [N-1:0]            strobe_q;
  logic                    tdo_q;
  logic                    capture_en, shift_en, update_en;
  logic                    full_single, full_burst, cand, parity_ok, commit;
  logic [AW-1:0]           cand_idx;
  logic [W-1:0]            cand_data;

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // UDR wins over a simultaneous CDR; UDR seen from IDLE has nothing to update
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cdr_rise && !udr_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: if (udr_rise) state_d = ST_UPDATE;
                  else if (sdr_rise) state_d = ST_SHIFT;
      ST_SHIFT:   if (udr_rise) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture_en = (state_q == ST_IDLE) && (state_d == ST_CAPTURE);
    shift_en   = (state_q == ST_SHIFT) && (state_d == ST_SHIFT) && tck_rise;
    update_en  = (state_q != ST_UPDATE) && (state_d == ST_UPDATE);
  end

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < N; i++) begin
      if (iADDRESS[AW-1:0] == AW'(i)) cap_data = iDATA[i];
    end
    if (iADDRESS[AW-1:0] == AW'(N)) cap_data = REGISTER_SIZE'(JTAG_BANK_ID);
    if (opcode_e'(iADDRESS[IR_WIDTH-1 -: 2]) == OP_WRITE ||
        opcode_e'(iADDRESS[IR_WIDTH-1 -: 2]) == OP_BURST_WRITE) cap_data = '0;
`ifdef JTAG_BANK_PARITY_EN
    cap_word = {^cap_data, cap_data};
`else
    cap_word = cap_data;
`endif
  end

  assign shifted = {iTDI, shift_q[W-1:1]};

  // A burst word completes on the shift that brings the counter to W
  always_comb begin
    full_single = update_en && (op_q == OP_WRITE || op_q == OP_READ_WRITE) && (count_q == CW'(W));
    full_burst  = shift_en && (op_q == OP_BURST_WRITE) && (count_q == CW'(W - 1));
    cand        = full_single || full_burst;
    cand_idx    = full_burst ? ptr_q : addr_q;
    cand_data   = full_burst ? shifted : shift_q;
`ifdef JTAG_BANK_PARITY_EN
    parity_ok   = ~^cand_data;
`else
    parity_ok   = 1'b1;
`endif
    commit      = cand && parity_ok && (addr_q < AW'(N));
  end

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      tdo_q    <= 1'b0;
    end else begin
      strobe_q <= '0;
      tdo_q    <= shift_q[0];
      if (capture_en) begin
        shift_q <= cap_word;
        count_q <= '0;
        addr_q  <= iADDRESS[AW-1:0];
        ptr_q   <= iADDRESS[AW-1:0];
        op_q    <= opcode_e'(iADDRESS[IR_WIDTH-1 -: 2]);
      end else if (shift_en) begin
        shift_q <= shifted;
        if (full_burst) begin
          count_q <= '0;
          ptr_q   <= (ptr_q == AW'(N - 1)) ? '0 : ptr_q + 1'b1;
        end else if (count_q != CW'(W)) begin
          count_q <= count_q + 1'b1;
        end
      end
      if (commit) begin
        for (int i = 0; i < N; i++) begin
          if (cand_idx == AW'(i)) begin
            data_q[i]   <= cand_data[REGISTER_SIZE-1:0];
            strobe_q[i] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef JTAG_BANK_PARITY_EN
  logic [7:0] perr_q;

  always_ff @(posedge iMAIN_CLK) begin
    if (iRESET) perr_q <= '0;
    else if (cand && !parity_ok && perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
  end

  assign oPARITY_ERRORS = perr_q;
`endif

  assign oDATA         = data_q;
  assign oWRITE_STROBE = strobe_q;
  assign oTDO          = tdo_q;

endmodule

// File: tb/tb_jtag_register_bank.sv
// tb/tb_jtag_register_bank.sv - directed self-checking bench for jtag_register_bank (4 x 8-bit)
// Also covers the parity word when built with JTAG_BANK_PARITY_EN.
module tb_jtag_register_bank;

`ifdef JTAG_BANK_PARITY_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif

  logic            iMAIN_CLK;
  logic            iRESET;
  logic [4:0]      iADDRESS;
  logic            iTCK, iTDI, iSTATE_CDR, iSTATE_SDR, iSTATE_UDR;
  logic            oTDO;
  logic [3:0][7:0] iDATA;
  logic [3:0][7:0] oDATA;
  logic [3:0]      oWRITE_STROBE;
`ifdef JTAG_BANK_PARITY_EN
  logic [7:0]      perr;
`endif

  jtag_register_bank dut (
    .iMAIN_CLK     (iMAIN_CLK),
    .iRESET        (iRESET),
    .iADDRESS      (iADDRESS),
    .iTCK          (iTCK),
    .iTDI          (iTDI),
    .iSTATE_CDR    (iSTATE_CDR),
    .iSTATE_SDR    (iSTATE_SDR),
    .iSTATE_UDR    (iSTATE_UDR),
    .oTDO          (oTDO),
    .iDATA         (iDATA),
    .oDATA         (oDATA),
    .oWRITE_STROBE (oWRITE_STROBE)
`ifdef JTAG_BANK_PARITY_EN
    ,
    .oPARITY_ERRORS(perr)
`endif
  );

  initial iMAIN_CLK = 1'b0;
  always #5 iMAIN_CLK = ~iMAIN_CLK;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] strobe_log[$];
  logic [3:0] udr_strobe;
  logic [31:0] udr_data;
  logic [31:0] seq;

  always @(negedge iMAIN_CLK) begin
    if (oWRITE_STROBE != 4'b0) strobe_log.push_back(oWRITE_STROBE);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iMAIN_CLK);
    #1;
  endtask

  function automatic logic [W-1:0] enc(input logic [7:0] d);
`ifdef JTAG_BANK_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic capture(input logic [1:0] op, input logic [2:0] addr);
    strobe_log.delete();
    iADDRESS = {op, addr};
    iSTATE_CDR = 1'b1; tick(3); iSTATE_CDR = 1'b0; tick(2);
    iSTATE_SDR = 1'b1; tick(3); iSTATE_SDR = 1'b0; tick(2);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n, output logic [31:0] tdo_seq);
    tdo_seq = '0;
    for (int i = 0; i < n; i++) begin
      tdo_seq[i] = oTDO;
      iTDI = d[i];
      iTCK = 1'b1; tick(3);
      iTCK = 1'b0; tick(2);
    end
  endtask

  task automatic update();
    iSTATE_UDR = 1'b1; tick(2);
    udr_strobe = oWRITE_STROBE;
    udr_data   = oDATA;
    tick(1);
    iSTATE_UDR = 1'b0; tick(3);
  endtask

  task automatic xfer(input logic [1:0] op, input logic [2:0] addr, input logic [31:0] d,
                      input int n, output logic [31:0] tdo_seq);
    capture(op, addr);
    shift_bits(d, n, tdo_seq);
    update();
  endtask

  initial begin
    iRESET = 1'b1; iADDRESS = '0; iTCK = 0; iTDI = 0;
    iSTATE_CDR = 0; iSTATE_SDR = 0; iSTATE_UDR = 0;
    iDATA = {8'hC3, 8'h96, 8'h3C, 8'h81};
    tick(3);
    check("rst_data", oDATA, 32'h0);
    check("rst_strobe", oWRITE_STROBE, 4'h0);
    check("rst_tdo", oTDO, 1'b0);
`ifdef JTAG_BANK_PARITY_EN
    check("rst_perr", perr, 8'h0);
`endif
    iRESET = 1'b0; tick(2);

    xfer(2'b01, 3'd2, enc(8'hA5), W, seq);
    check("wr_commit_time", udr_data, 32'h00A50000);
    check("wr_strobe", udr_strobe, 4'b0100);
    check("wr_strobe_len", strobe_log.size(), 1);
    check("wr_data", oDATA, 32'h00A50000);

    xfer(2'b00, 3'd1, 32'h0, W, seq);
    check("rd_seq", seq, enc(8'h3C));
    check("rd_data", oDATA, 32'h00A50000);
    check("rd_no_strobe", strobe_log.size(), 0);

    capture(2'b11, 3'd3);
    shift_bits(enc(8'h11), W, seq);
    shift_bits(enc(8'h22), W, seq);
    shift_bits(enc(8'h33), W, seq);
    shift_bits(32'h7, 3, seq);
    update();
    check("burst_data", oDATA, 32'h11A53322);
    check("burst_n", strobe_log.size(), 3);
    if (strobe_log.size() == 3) begin
      check("burst_s0", strobe_log[0], 4'b1000);
      check("burst_s1", strobe_log[1], 4'b0001);
      check("burst_s2", strobe_log[2], 4'b0010);
    end

    xfer(2'b01, 3'd0, 32'h1F, 5, seq);
    check("short_data", oDATA, 32'h11A53322);
    check("short_strobe", strobe_log.size(), 0);

    xfer(2'b00, 3'd4, 32'h0, W, seq);
    check("id_seq", seq, enc(8'h47));
    xfer(2'b01, 3'd4, enc(8'h99), W, seq);
    check("id_wr_data", oDATA, 32'h11A53322);
    check("id_wr_strobe", strobe_log.size(), 0);
    xfer(2'b00, 3'd5, 32'h0, W, seq);
    check("bad_addr_seq", seq, 32'h0);

    xfer(2'b10, 3'd1, enc(8'h5A), W, seq);
    check("rw_seq", seq, enc(8'h3C));
    check("rw_data", oDATA, 32'h11A55A22);
    check("rw_strobe", udr_strobe, 4'b0010);

    // CDR and UDR together: capture must not happen, so the write is dropped
    strobe_log.delete();
    iADDRESS = {2'b01, 3'd0};
    iSTATE_CDR = 1'b1; iSTATE_UDR = 1'b1; tick(3);
    iSTATE_CDR = 1'b0; iSTATE_UDR = 1'b0; tick(2);
    iSTATE_SDR = 1'b1; tick(3); iSTATE_SDR = 1'b0; tick(2);
    shift_bits(enc(8'h77), W, seq);
    update();
    check("cdr_udr_data", oDATA, 32'h11A55A22);
    check("cdr_udr_strobe", strobe_log.size(), 0);

    capture(2'b01, 3'd1);
    shift_bits(32'hF, 4, seq);
    iRESET = 1'b1; iSTATE_UDR = 1'b1; tick(3);
    check("mid_rst_data", oDATA, 32'h0);
    check("mid_rst_tdo", oTDO, 1'b0);
    check("mid_rst_strobe", strobe_log.size(), 0);
    iRESET = 1'b0; tick(3);
    iSTATE_UDR = 1'b0; tick(2);
    update();
    check("post_rst_strobe", strobe_log.size(), 0);
    check("post_rst_data", oDATA, 32'h0);

`ifdef JTAG_BANK_PARITY_EN
    xfer(2'b01, 3'd2, {1'b1, 8'hA5}, W, seq);
    check("par_bad_strobe", strobe_log.size(), 0);
    check("par_bad_data", oDATA, 32'h0);
    check("par_bad_cnt", perr, 8'd1);
    xfer(2'b01, 3'd2, {1'b0, 8'hA5}, W, seq);
    check("par_ok_data", oDATA, 32'h00A50000);
    check("par_ok_strobe", udr_strobe, 4'b0100);
    check("par_ok_cnt", perr, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_register_bank.md
JTAG_REGISTER_BANK -- requirements
Module: jtag_register_bank

Interface
REQ-001 The block SHALL have parameter REGISTER_SIZE, default 8, which sets the bits per register.
REQ-002 The block SHALL have parameter NUMBER_OF_REGISTERS, default 4, which sets the register count.
REQ-003 The block SHALL have derived localparam ADDRESS_WIDTH = $clog2(NUMBER_OF_REGISTERS+1) and IR_WIDTH = ADDRESS_WIDTH+2.
REQ-004 Port iMAIN_CLK, input, 1 bit: the single clock for all logic.
REQ-005 Port iRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port iADDRESS, input, IR_WIDTH bits: the virtual IR, with {opcode[1:0], address}.
REQ-007 Ports iTCK, iTDI, iSTATE_CDR, iSTATE_SDR, iSTATE_UDR, inputs, 1 bit each: JTAG levels already synchronised to iMAIN_CLK.
REQ-008 Port oTDO, output, 1 bit: the serial readout.
REQ-009 Port iDATA, input, [NUMBER_OF_REGISTERS-1:0][REGISTER_SIZE-1:0]: the read sources.
REQ-010 Port oDATA, output, same shape as iDATA: the written registers.
REQ-011 Port oWRITE_STROBE, output, NUMBER_OF_REGISTERS bits: a one-cycle pulse per committed write.

Function
REQ-012 Opcodes SHALL be 00 READ, 01 WRITE, 10 READ_WRITE and 11 BURST_WRITE.
REQ-013 The FSM SHALL have states IDLE, CAPTURE, SHIFT and UPDATE; transitions occur on rising edges of the CDR, SDR and UDR levels, detected one cycle after the level change.
REQ-014 CAPTURE SHALL load the shift register with iDATA[addr] for READ and READ_WRITE, and with zero for the other opcodes, and SHALL clear the bit counter.
REQ-015 In SHIFT, each detected iTCK rising edge SHALL perform shift <= {iTDI, shift[W-1:1]} and increment the bit counter, which saturates at W; data is LSB first.
REQ-016 oTDO SHALL be registered and SHALL equal shift[0] one cycle after each CAPTURE or shift.
REQ-017 iTCK edges outside SHIFT SHALL be ignored.
REQ-018 For WRITE and READ_WRITE, on UPDATE entry with counter==W, the block SHALL set oDATA[addr] to the shift data in the next cycle and pulse oWRITE_STROBE[addr] for exactly one cycle.
REQ-019 For WRITE and READ_WRITE, on UPDATE entry with counter<W, the block SHALL discard the data: no change and no strobe.
REQ-020 In BURST_WRITE, each time the counter reaches W the block SHALL commit to oDATA[ptr], strobe ptr, reset the counter to 0 and advance ptr.
REQ-021 In BURST_WRITE, ptr SHALL start at addr and wrap from NUMBER_OF_REGISTERS-1 to 0.
REQ-022 In BURST_WRITE, on UPDATE any partial word SHALL be discarded.
REQ-023 address == NUMBER_OF_REGISTERS SHALL select the ID register, which captures JTAG_BANK_ID truncated to REGISTER_SIZE and ignores writes.
REQ-024 Addresses above NUMBER_OF_REGISTERS SHALL capture zero and ignore writes.
REQ-025 If CDR and UDR rise in the same cycle, UDR SHALL take priority and CDR SHALL be ignored.
REQ-026 UPDATE SHALL return to IDLE after one cycle.
REQ-027 iADDRESS SHALL be latched at CAPTURE and held until IDLE.

Reset
REQ-028 While iRESET is high: oDATA=0, oWRITE_STROBE=0, oTDO=0, state=IDLE, counter=0, ptr=0, shift=0, and the edge-detector history=0.
REQ-029 A reset asserted mid-SHIFT SHALL abort the transfer; no write commits, including a UDR rise seen in the same cycle.

Configuration
REQ-030 With JTAG_BANK_PARITY_EN defined:
- W = REGISTER_SIZE+1, with the top bit carrying even parity.
- CAPTURE appends the parity of the captured data.
- A commit occurs only if the parity matches.
- A mismatch increments output oPARITY_ERRORS (8 bits, saturating at 255, reset to 0).
REQ-031 Without JTAG_BANK_PARITY_EN: W = REGISTER_SIZE, no parity is checked, and port oPARITY_ERRORS is absent.

Structure
REQ-032 Package jtag_bank_pkg SHALL hold the opcode enum, the FSM state enum and constant JTAG_BANK_ID = 32'h4A544147.
REQ-033 Sub-module jtag_edge_detect SHALL provide the registered rising-edge pulses for iTCK, iSTATE_CDR, iSTATE_SDR and iSTATE_UDR; it is instantiated once per signal.

Verification (REGISTER_SIZE=8, NUMBER_OF_REGISTERS=4)
REQ-034 WRITE addr 2, shift 0xA5, UDR -> oDATA[2]=0xA5 one cycle after UDR is detected, oWRITE_STROBE=4'b0100 for one cycle, other registers unchanged.
REQ-035 READ addr 1 with iDATA[1]=0x3C -> oTDO sequence 0,0,1,1,1,1,0,0, and oDATA unchanged.
REQ-036 BURST_WRITE addr 3, shift 0x11,0x22,0x33, then 3 extra bits, then UDR -> oDATA[3]=0x11, oDATA[0]=0x22, oDATA[1]=0x33, three strobes in that order, and the partial bits dropped.
REQ-037 WRITE addr 0 with only 5 bits, then UDR -> oDATA[0] unchanged and no strobe; READ addr 4 -> serial 0x47; WRITE addr 4 -> no effect.
REQ-038 iRESET asserted after 4 shifted bits of WRITE addr 1 -> all outputs 0; a following UDR produces no strobe.
REQ-039 With JTAG_BANK_PARITY_EN: shift 0xA5 with parity bit 1 -> no write, oPARITY_ERRORS=1; shift 0xA5 with parity bit 0 -> commit.
